fpdiv_issue_ctrl: RTL

Hardware initiator for the iterative fpdiv/sqrt unit.
- Accepts one operation at a time on a valid/ready request port.
- Drives the unit's operand/control lines and multi-cycle start pulse.
- Waits for completion, captures result/flags, and presents them on a valid/ready response port.
- Sits between the issue logic and fpdiv; replaces the bench-side start/done sequencing in silicon, with a watchdog for a hung unit.

---
 rtl/fpdiv_issue_ctrl.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/fpdiv_issue_ctrl.sv
// Issue controller for the iterative fpdiv/sqrt unit.
// Takes one operation at a time on a valid/ready request port, registers the operands
// onto the unit's inputs, pulses div_start for START_CYCLES cycles, then waits for a
// rising edge on div_done. The captured result is presented on a valid/ready response
// port. A watchdog aborts the operation if no completion arrives within TIMEOUT cycles.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   in_*                       request channel (valid/ready, operands, mode bits)
//   div_*  (out)               registered operands/control and start pulse to fpdiv
//   div_done/result/flags/denorm  completion and result from fpdiv
//   res_*                      response channel (valid/ready, result, flags, timeout)
//   op_count                   completed responses including timeouts, wraps
module fpdiv_issue_ctrl #(
  parameter int unsigned START_CYCLES = 2,
  parameter int unsigned TIMEOUT      = 63,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      in_op1,
  input  logic [63:0]      in_op2,
  input  logic [2:0]       in_rm,
  input  logic             in_op_type,
  input  logic             in_p,
  input  logic             in_oven,
  input  logic             in_unen,
  output logic             div_start,
  output logic [63:0]      div_op1,
  output logic [63:0]      div_op2,
  output logic [2:0]       div_rm,
  output logic             div_op_type,
  output logic             div_p,
  output logic             div_oven,
  output logic             div_unen,
  input  logic             div_done,
  input  logic [63:0]      div_result,
  input  logic [4:0]       div_flags,
  input  logic             div_denorm,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [63:0]      res_data,
  output logic [4:0]       res_flags,
  output logic             res_denorm,
  output logic             res_timeout,
  output logic [CNT_W-1:0] op_count
);

  localparam logic [3:0] StartLast = 4'(START_CYCLES - 1);
  localparam logic [7:0] WdLast    = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StStart, StWait, StResp} state_e;

  state_e     state_q, state_d;
  logic [3:0] start_cnt_q, start_cnt_d;
  logic [7:0] wd_q, wd_d;
  logic       done_prev_q;
  logic       accept, done_edge, capture, timeout_hit, res_hs;

  // Outputs decoded from state so reset drops div_start without waiting for a clock.
  assign in_ready  = (state_q == StIdle);
  assign div_start = (state_q == StStart);
  assign res_valid = (state_q == StResp);

  assign accept    = in_valid & in_ready;
  assign res_hs    = res_valid & res_ready;
  // done_prev_q tracks div_done every cycle, so a level still high from the previous
  // operation on WAIT entry reads as "previous = 1" and never forms an edge.
  assign done_edge = div_done & ~done_prev_q;

  always_comb begin
    state_d     = state_q;
    start_cnt_d = start_cnt_q;
    wd_d        = wd_q;
    capture     = 1'b0;
    timeout_hit = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d     = StStart;
          start_cnt_d = '0;
        end
      end
      StStart: begin
        if (start_cnt_q == StartLast) begin
          state_d = StWait;
          wd_d    = '0;
        end else begin
          start_cnt_d = start_cnt_q + 4'd1;
        end
      end
      StWait: begin
        if (done_edge) begin
          capture = 1'b1;
          state_d = StResp;
        end else if (wd_q == WdLast) begin
          timeout_hit = 1'b1;
          state_d     = StResp;
        end else begin
          wd_d = wd_q + 8'd1;
        end
      end
      StResp: begin
        if (res_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      start_cnt_q <= '0;
      wd_q        <= '0;
      done_prev_q <= 1'b0;
      div_op1     <= '0;
      div_op2     <= '0;
      div_rm      <= '0;
      div_op_type <= 1'b0;
      div_p       <= 1'b0;
      div_oven    <= 1'b0;
      div_unen    <= 1'b0;
      res_data    <= '0;
      res_flags   <= '0;
      res_denorm  <= 1'b0;
      res_timeout <= 1'b0;
      op_count    <= '0;
    end else begin
      state_q     <= state_d;
      start_cnt_q <= start_cnt_d;
      wd_q        <= wd_d;
      done_prev_q <= div_done;
      if (accept) begin
        div_op1     <= in_op1;
        div_op2     <= in_op2;
        div_rm      <= in_rm;
        div_op_type <= in_op_type;
        div_p       <= in_p;
        div_oven    <= in_oven;
        div_unen    <= in_unen;
      end
      if (capture) begin
        res_data    <= div_result;
        res_flags   <= div_flags;
        res_denorm  <= div_denorm;
        res_timeout <= 1'b0;
      end else if (timeout_hit) begin
        res_data    <= '0;
        res_flags   <= '0;
        res_denorm  <= 1'b0;
        res_timeout <= 1'b1;
      end
      if (res_hs) op_count <= op_count + 1'b1;
    end
  end

endmodule
